ebpf_div_scheduler: RTL and testbench

- Shared multi-cycle unsigned divide/modulo engine for the eBPF core, arbitrated between two requesters (e.g. two execute lanes).
- Replaces a single-cycle combinational divide with a radix-2 restoring shift-subtract sequencer, one bit per cycle.
- Implements eBPF semantics: unsigned operands, ALU32/ALU64 widths, and defined divide-by-zero results.
- Holds one operation in flight; results return on a shared response channel tagged with the requester ID.

---
 rtl/ebpf_div_scheduler_if.sv | 27 ++
 rtl/ebpf_div_scheduler.sv | 150 +++++++++++++++
 tb/tb_ebpf_div_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebpf_div_scheduler_if.sv
// Request/response bundle between two eBPF execute lanes and the shared divider.
// A request or response transfers on a rising clk edge where its valid and ready are both high.
// Once raised, a valid stays high with stable payload until that transfer.
interface ebpf_div_scheduler_if #(
  parameter int W = 64
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_mod;
  logic [1:0]     req_alu32;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [W-1:0]   resp_result;

  modport master (
    output req_valid, req_a, req_b, req_mod, req_alu32, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mod, req_alu32, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result
  );
endinterface

// File: rtl/ebpf_div_scheduler.sv
// Shared radix-2 restoring divide/modulo engine for two eBPF requesters.
// One operation in flight; round-robin grant; eBPF divide-by-zero semantics.
module ebpf_div_scheduler #(
  parameter int W   = 64,
  parameter int W32 = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ebpf_div_scheduler_if.slave   bus,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MASK32 = W'({W32{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic          last_grant_q;
  logic          id_q;
  logic          mod_q;
  logic          alu32_q;
  logic [W-1:0]  divisor_q;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  result_q;
  logic          resp_valid_q;

  logic          grant_id;
  logic [1:0]    ready;
  logic          accept;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;
  logic [W-1:0]  a_eff;
  logic [W-1:0]  b_eff;
  logic          op_mod;
  logic          op_alu32;

  logic [W:0]    rem_shift;
  logic [W:0]    diff;
  logic          ge;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quot_next;
  logic [W-1:0]  res_raw;

  // Grant depends only on valids and last_grant so it never waits on operand timing.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req_valid == 2'b11) grant_id = ~last_grant_q;
    else                        grant_id = ~bus.req_valid[0];
    ready = 2'b00;
    if (state_q == S_IDLE && (|bus.req_valid)) ready = grant_id ? 2'b10 : 2'b01;
  end

  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);

  always_comb begin
    a_sel    = grant_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
    b_sel    = grant_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
    op_mod   = bus.req_mod[grant_id];
    op_alu32 = bus.req_alu32[grant_id];
    a_eff    = op_alu32 ? (a_sel & MASK32) : a_sel;
    b_eff    = op_alu32 ? (b_sel & MASK32) : b_sel;
  end

  // The remainder fits in W bits, but the shifted partial needs one spare bit.
  always_comb begin
    rem_shift = {rem_q, quot_q[W-1]};
    diff      = rem_shift - {1'b0, divisor_q};
    ge        = ~diff[W];
    rem_next  = ge ? diff[W-1:0] : rem_shift[W-1:0];
    quot_next = {quot_q[W-2:0], ge};
    res_raw   = mod_q ? rem_next : quot_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      mod_q        <= 1'b0;
      alu32_q      <= 1'b0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            mod_q        <= op_mod;
            alu32_q      <= op_alu32;
            divisor_q    <= b_eff;
            rem_q        <= '0;
            // ALU32 dividends are left-aligned so the same shifter consumes only W32 bits.
            quot_q       <= op_alu32 ? (a_eff << (W - W32)) : a_eff;
            cnt_q        <= op_alu32 ? CW'(W32) : CW'(W);
            if (b_eff == '0) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              result_q     <= op_mod ? a_eff : '0;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            result_q     <= alu32_q ? (res_raw & MASK32) : res_raw;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          result_q     <= '0;
        end
      endcase
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign busy            = (state_q != S_IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ebpf_div_scheduler.sv
// Directed bench for ebpf_div_scheduler: arithmetic/queue model checked every cycle
// plus literal expectations for each scenario.
module tb_ebpf_div_scheduler;
  localparam int W = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy;
  logic [1:0] dbg_state;

  ebpf_div_scheduler_if #(.W(W)) bus ();

  ebpf_div_scheduler #(.W(W), .W32(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  bit           m_id   = 1'b0;
  int           m_wait = 0;

  function automatic logic [W-1:0] eff(input logic [W-1:0] v, input logic al);
    return al ? {32'b0, v[31:0]} : v;
  endfunction

  function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m, input logic al);
    logic [W-1:0] ae, be;
    ae = eff(a, al);
    be = eff(b, al);
    if (be == 0) return m ? ae : '0;
    return m ? (ae % be) : (ae / be);
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic al);
    if (eff(b, al) == 0) return 1;
    return al ? 33 : 65;
  endfunction

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       g;
    bit         exp_valid;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_wait = 0;
      exp_q.delete();
    end
    exp_ready = 2'b00;
    if (!m_busy && bus.req_valid != 2'b00)
      exp_ready = (bus.req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : bus.req_valid;
    check("req_ready", {62'b0, bus.req_ready}, {62'b0, exp_ready});
    check("busy", {63'b0, busy}, {63'b0, m_busy});
    exp_valid = m_busy && (m_wait == 0);
    check("resp_valid", {63'b0, bus.resp_valid}, {63'b0, exp_valid});
    if (exp_valid && exp_q.size() > 0) begin
      check("resp_result", bus.resp_result, exp_q[0]);
      check("resp_id", {63'b0, bus.resp_id}, {63'b0, m_id});
    end else begin
      check("resp_result_idle", bus.resp_result, '0);
    end
    if (!rst_n) check("resp_id_reset", {63'b0, bus.resp_id}, '0);

    if (rst_n) begin
      if (!m_busy) begin
        if (exp_ready != 2'b00) begin
          g = exp_ready[1];
          exp_q.push_back(model_res(bus.req_a[g*W +: W], bus.req_b[g*W +: W],
                                    bus.req_mod[g], bus.req_alu32[g]));
          m_wait = model_lat(bus.req_b[g*W +: W], bus.req_alu32[g]) - 1;
          m_busy = 1'b1;
          m_id   = g;
          m_last = g;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.resp_ready) begin
        m_busy = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] id_log[$];
  logic [W-1:0] res_log[$];
  int           lat_log[$];

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m, input logic al);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_mod[id]      = m;
    bus.req_alu32[id]    = al;
    bus.req_valid[id]    = 1'b1;
  endtask

  // Runs until n responses are taken; drops each valid after its handshake unless keep.
  task automatic pump(input int n, input bit keep);
    int cyc = 0;
    int got = 0;
    int t_hs = 0;
    logic [1:0] hs;
    id_log.delete();
    res_log.delete();
    lat_log.delete();
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      hs = bus.req_valid & bus.req_ready;
      if (hs != 2'b00) t_hs = cyc;
      if (bus.resp_valid && bus.resp_ready) begin
        got++;
        id_log.push_back({63'b0, bus.resp_id});
        res_log.push_back(bus.resp_result);
        lat_log.push_back(cyc - t_hs);
      end
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = bus.req_valid & ~hs;
    end
    if (keep) bus.req_valid = 2'b00;
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL pump_timeout: got=%0d responses expected=%0d", got, n);
    end
  endtask

  task automatic chk_op(input string nm, input int i, input logic exp_id,
                        input logic [W-1:0] exp_res, input int exp_lat);
    if (i >= res_log.size()) begin
      total++;
      bad++;
      $display("FAIL %s_missing: got=%0d responses expected>%0d", nm, res_log.size(), i);
    end else begin
      check({nm, "_result"}, res_log[i], exp_res);
      check({nm, "_id"}, id_log[i], {63'b0, exp_id});
      if (exp_lat > 0) check({nm, "_latency"}, W'(lat_log[i]), W'(exp_lat));
    end
  endtask

  task automatic wait_ready(input int id);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.req_ready[id] && cyc < 200);
    if (!bus.req_ready[id]) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got=0 expected=requester %0d granted", id);
    end
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_mod    = 2'b00;
    bus.req_alu32  = 2'b00;
    bus.resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_resp_valid", {63'b0, bus.resp_valid}, '0);
    check("rst_busy", {63'b0, busy}, '0);
    check("rst_resp_result", bus.resp_result, '0);
    check("rst_resp_id", {63'b0, bus.resp_id}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic ALU64 divide and ALU32 modulo with dirty upper bits.
    issue(0, 64'd100, 64'd7, 1'b0, 1'b0);
    pump(1, 1'b0);
    chk_op("div64", 0, 1'b0, 64'd14, 65);
    issue(1, 64'hFFFF_FFFF_0000_0064, 64'd7, 1'b1, 1'b1);
    pump(1, 1'b0);
    chk_op("mod32", 0, 1'b1, 64'd2, 33);

    // Divide by zero, including an ALU32 divisor that is zero only in its low half.
    issue(0, 64'd55, 64'd0, 1'b0, 1'b0);
    pump(1, 1'b0);
    chk_op("div0", 0, 1'b0, 64'd0, 1);
    issue(0, 64'd55, 64'd0, 1'b1, 1'b0);
    pump(1, 1'b0);
    chk_op("mod0", 0, 1'b0, 64'd55, 1);
    issue(1, 64'hDEAD_BEEF_1234_5678, 64'h1_0000_0000, 1'b1, 1'b1);
    pump(1, 1'b0);
    chk_op("mod0_32", 0, 1'b1, 64'h1234_5678, 1);

    // Both requesters valid continuously: grants alternate.
    issue(0, 64'd1000, 64'd10, 1'b0, 1'b1);
    issue(1, 64'd1000, 64'd3, 1'b1, 1'b0);
    pump(4, 1'b1);
    chk_op("alt0", 0, 1'b0, 64'd100, 0);
    chk_op("alt1", 1, 1'b1, 64'd1, 0);
    chk_op("alt2", 2, 1'b0, 64'd100, 0);
    chk_op("alt3", 3, 1'b1, 64'd1, 0);

    // Back-pressure: result held while the other requester waits.
    bus.resp_ready = 1'b0;
    issue(0, 64'd1000, 64'd9, 1'b0, 1'b1);
    issue(1, 64'd77, 64'd0, 1'b0, 1'b0);
    wait_ready(0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.resp_valid && cyc < 100);
    for (int i = 0; i < 10; i++) begin
      check("bp_result", bus.resp_result, 64'd111);
      check("bp_id", {63'b0, bus.resp_id}, '0);
      check("bp_no_grant", {62'b0, bus.req_ready}, '0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    pump(2, 1'b0);
    chk_op("bp_first", 0, 1'b0, 64'd111, 0);
    chk_op("bp_second", 1, 1'b1, 64'd0, 0);

    // Reset in the middle of an ALU64 operation.
    issue(0, 64'd12345, 64'd3, 1'b0, 1'b0);
    wait_ready(0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", {63'b0, bus.resp_valid}, '0);
    check("midrst_busy", {63'b0, busy}, '0);
    check("midrst_resp_result", bus.resp_result, '0);
    check("midrst_resp_id", {63'b0, bus.resp_id}, '0);
    issue(1, 64'd5, 64'd0, 1'b1, 1'b0);
    issue(0, 64'd6, 64'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pump(2, 1'b0);
    chk_op("postrst_first", 0, 1'b0, 64'd6, 0);
    chk_op("postrst_second", 1, 1'b1, 64'd5, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
